// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : MEM-stage load/store unit with a req/ack data-memory port,
//                byte-lane formatting, misalignment and bus-timeout detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int AW      = 30,
    parameter int TIMEOUT = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [31:0]   EX_MEM_Instr,
    input  logic [31:0]   EX_MEM_ALU_o,
    input  logic [31:0]   EX_MEM_RtData,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_ack,
    output logic [31:0]   dataMem_o,
    output logic          mem_stall,
    output logic          addr_exc,
    output logic          bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [5:0] c_OP_LB  = 6'h20;
    localparam logic [5:0] c_OP_LH  = 6'h21;
    localparam logic [5:0] c_OP_LW  = 6'h23;
    localparam logic [5:0] c_OP_LBU = 6'h24;
    localparam logic [5:0] c_OP_LHU = 6'h25;
    localparam logic [5:0] c_OP_SB  = 6'h28;
    localparam logic [5:0] c_OP_SH  = 6'h29;
    localparam logic [5:0] c_OP_SW  = 6'h2B;

    localparam logic [1:0] c_SZ_B = 2'd0;
    localparam logic [1:0] c_SZ_H = 2'd1;
    localparam logic [1:0] c_SZ_W = 2'd2;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_load;
    logic          r_sext;
    logic [1:0]    r_size;
    logic [1:0]    r_lane;

    logic [5:0]    w_opcode;
    logic [1:0]    w_addr_lo;
    logic          w_load;
    logic          w_store;
    logic          w_sext;
    logic [1:0]    w_size;
    logic          w_mem_op;
    logic          w_misalign;
    logic          w_idle;
    logic          w_go;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_fmt;
    logic          w_unused;

    assign w_opcode  = EX_MEM_Instr[31:26];
    assign w_addr_lo = EX_MEM_ALU_o[1:0];
    assign w_unused  = &{1'b0, EX_MEM_Instr[25:0], EX_MEM_ALU_o};

    always_comb begin
        w_load  = 1'b0;
        w_store = 1'b0;
        w_sext  = 1'b0;
        w_size  = c_SZ_B;
        case (w_opcode)
            c_OP_LB:  begin w_load  = 1'b1; w_sext = 1'b1;                  end
            c_OP_LH:  begin w_load  = 1'b1; w_sext = 1'b1; w_size = c_SZ_H; end
            c_OP_LW:  begin w_load  = 1'b1;                w_size = c_SZ_W; end
            c_OP_LBU: begin w_load  = 1'b1;                                 end
            c_OP_LHU: begin w_load  = 1'b1;                w_size = c_SZ_H; end
            c_OP_SB:  begin w_store = 1'b1;                                 end
            c_OP_SH:  begin w_store = 1'b1;                w_size = c_SZ_H; end
            c_OP_SW:  begin w_store = 1'b1;                w_size = c_SZ_W; end
            default:  ;
        endcase
    end

    assign w_mem_op   = w_load | w_store;
    assign w_misalign = ((w_size == c_SZ_H) & w_addr_lo[0]) |
                        ((w_size == c_SZ_W) & (|w_addr_lo));
    assign w_idle     = (r_state == c_IDLE);
    assign w_go       = RSTn & w_idle & w_mem_op & ~w_misalign;

    // Gated by RSTn so neither flag can leak out while reset is held.
    assign addr_exc   = RSTn & w_idle & w_mem_op & w_misalign;
    assign mem_stall  = w_go | (RSTn & (r_state == c_WAIT));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = EX_MEM_RtData;
        case (w_size)
            c_SZ_B: begin
                w_be    = 4'b0001 << w_addr_lo;
                w_wdata = {4{EX_MEM_RtData[7:0]}};
            end
            c_SZ_H: begin
                w_be    = w_addr_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{EX_MEM_RtData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_lane)
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            2'd3:    w_byte = dmem_rdata[31:24];
            default: ;
        endcase
    end

    assign w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_load_fmt = dmem_rdata;
        case (r_size)
            c_SZ_B:  w_load_fmt = {{24{r_sext & w_byte[7]}}, w_byte};
            c_SZ_H:  w_load_fmt = {{16{r_sext & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_load     <= 1'b0;
            r_sext     <= 1'b0;
            r_size     <= c_SZ_B;
            r_lane     <= 2'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'd0;
            dataMem_o  <= 32'd0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_go) begin
                        r_load     <= w_load;
                        r_sext     <= w_sext;
                        r_size     <= w_size;
                        r_lane     <= w_addr_lo;
                        r_cnt      <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= w_store;
                        dmem_addr  <= EX_MEM_ALU_o[AW+1:2];
                        dmem_be    <= w_be;
                        dmem_wdata <= w_wdata;
                        r_state    <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    // An ack arriving on the final counted cycle still wins.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (r_load) begin
                            dataMem_o <= w_load_fmt;
                        end
                        r_state <= c_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        bus_err  <= 1'b1;
                        if (r_load) begin
                            dataMem_o <= 32'd0;
                        end
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_lsu
//  Description : Randomised self-checking bench for mem_stage_lsu against a
//                byte-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam int AW = 30;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic [31:0]   instr;
    logic [31:0]   alu;
    logic [31:0]   rt;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack;
    logic [31:0]   dm;
    logic          stall;
    logic          aexc;
    logic          berr;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_dm  = 32'd0;

    mem_stage_lsu #(.AW(AW), .TIMEOUT(TO)) u_dut (
        .CLK           (clk),
        .RSTn          (rst_n),
        .EX_MEM_Instr  (instr),
        .EX_MEM_ALU_o  (alu),
        .EX_MEM_RtData (rt),
        .dmem_req      (req),
        .dmem_we       (we),
        .dmem_addr     (addr),
        .dmem_be       (be),
        .dmem_wdata    (wdata),
        .dmem_rdata    (rdata),
        .dmem_ack      (ack),
        .dataMem_o     (dm),
        .mem_stall     (stall),
        .addr_exc      (aexc),
        .bus_err       (berr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    endfunction

    function automatic int lane_off(input int n, input logic [31:0] a);
        return (n == 4) ? 0 : ((a % 4) / n) * n;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                               input logic [31:0] rd);
        int          n;
        logic [31:0] mask;
        logic [31:0] v;
        n    = op_bytes(op);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = (rd >> (8 * lane_off(n, a))) & mask;
        if ((op == 6'h20 || op == 6'h21) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_be(input int n, input logic [31:0] a);
        int b;
        b = ((1 << n) - 1) << lane_off(n, a);
        return 32'(b[3:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input int n, input logic [31:0] d);
        if (n == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (n == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    // Runs one instruction through IDLE (and WAIT/DONE when a request is issued).
    // ack_at > TO means the memory never answers.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                          input int ack_at, input logic [31:0] rd);
        int  n;
        bit  st;
        bit  acked;
        n  = op_bytes(op);
        st = op_store(op);
        @(posedge clk); #1;
        instr = {op, 26'($urandom)};
        alu   = a;
        rt    = d;
        ack   = 1'b0;
        @(negedge clk);
        if (n == 0) begin
            check_eq("nop_stall", 32'(stall), 32'd0);
            check_eq("nop_exc",   32'(aexc),  32'd0);
            ack = 1'b1;
            rdata = $urandom;
            @(posedge clk); #1;
            ack = 1'b0;
            @(negedge clk);
            check_eq("nop_req", 32'(req), 32'd0);
            check_eq("nop_dm",  dm,       exp_dm);
            return;
        end
        if ((a % n) != 0) begin
            check_eq("mis_exc",   32'(aexc),  32'd1);
            check_eq("mis_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            instr = 32'd0;
            @(negedge clk);
            check_eq("mis_req", 32'(req), 32'd0);
            check_eq("mis_dm",  dm,       exp_dm);
            return;
        end
        check_eq("idle_stall", 32'(stall), 32'd1);
        check_eq("idle_exc",   32'(aexc),  32'd0);
        check_eq("idle_req",   32'(req),   32'd0);
        acked = 1'b0;
        for (int c = 1; c <= TO && !acked; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("wait_req",   32'(req),   32'd1);
            check_eq("wait_stall", 32'(stall), 32'd1);
            check_eq("wait_berr",  32'(berr),  32'd0);
            if (c == 1) begin
                check_eq("wait_we",    32'(we),  32'(st));
                check_eq("wait_addr",  32'(addr), a >> 2);
                check_eq("wait_be",    32'(be),  model_be(n, a));
                if (st) check_eq("wait_wdata", wdata, model_wdata(n, d));
            end
            if (c == ack_at) begin
                ack   = 1'b1;
                rdata = rd;
                acked = 1'b1;
            end else begin
                rdata = $urandom;
            end
        end
        @(posedge clk); #1;
        ack = 1'b0;
        if (!st) exp_dm = acked ? model_load(op, a, rd) : 32'd0;
        @(negedge clk);
        check_eq("done_stall", 32'(stall), 32'd0);
        check_eq("done_req",   32'(req),   32'd0);
        check_eq("done_berr",  32'(berr),  32'(!acked));
        check_eq("done_dm",    dm,         exp_dm);
    endtask

    function automatic logic [5:0] pick_op(input int i);
        case (i)
            0: return 6'h20;  1: return 6'h21;  2: return 6'h23;
            3: return 6'h24;  4: return 6'h25;  5: return 6'h28;
            6: return 6'h29;  7: return 6'h2B;  8: return 6'h00;
            default: return 6'h0F;
        endcase
    endfunction

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          dly;

        rst_n = 1'b0;
        instr = {6'h23, 26'd0};
        alu   = 32'h100;
        rt    = 32'd0;
        rdata = 32'd0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req",   32'(req),   32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_exc",   32'(aexc),  32'd0);
        check_eq("rst_berr",  32'(berr),  32'd0);
        check_eq("rst_dm",    dm,         32'd0);
        instr = 32'd0;
        rst_n = 1'b1;

        run_op(6'h23, 32'h100, 32'd0, 1, 32'hDEADBEEF);
        run_op(6'h20, 32'h203, 32'd0, 1, 32'h80112233);
        run_op(6'h24, 32'h203, 32'd0, 2, 32'h80112233);
        run_op(6'h21, 32'h202, 32'd0, 1, 32'h80112233);
        run_op(6'h28, 32'h011, 32'h000000A5, 1, 32'd0);
        run_op(6'h23, 32'h102, 32'd0, 1, 32'd0);
        run_op(6'h23, 32'h104, 32'd0, TO + 1, 32'd0);
        run_op(6'h25, 32'h006, 32'd0, TO, 32'hC3D4_1234);

        // Reset asserted in the middle of a WAIT.
        @(posedge clk); #1;
        instr = {6'h23, 26'd0};
        alu   = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("midrst_req_pre", 32'(req), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_dm = 32'd0;
        check_eq("midrst_req",   32'(req),   32'd0);
        check_eq("midrst_stall", 32'(stall), 32'd0);
        check_eq("midrst_dm",    dm,         32'd0);
        instr = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        ack   = 1'b1;
        rdata = 32'h1234_5678;
        @(posedge clk); #1;
        ack = 1'b0;
        @(negedge clk);
        check_eq("late_ack_req", 32'(req), 32'd0);
        check_eq("late_ack_dm",  dm,       32'd0);
        run_op(6'h23, 32'h300, 32'd0, 1, 32'hCAFE_F00D);

        for (int k = 0; k < 80; k++) begin
            op = pick_op($urandom_range(0, 9));
            a  = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
            dly = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(1, 4);
            run_op(op, a, $urandom, dly, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
